// File: rtl/d_sram_assoc_if.sv
// Access, flush and write-back signal bundle between the D-cache controller and its storage array.
interface d_sram_assoc_if #(
    parameter int WAYS        = 2,
    parameter int SETS        = 64,
    parameter int BLOCK_BYTES = 16,
    parameter int TAG_W       = 22
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ADDR_W  = TAG_W + INDEX_W;
    localparam int BLOCK_W = 8 * BLOCK_BYTES;

    logic                   en;
    logic                   wen;
    logic                   dmemWen;
    logic [BLOCK_BYTES-1:0] bytesAccess;
    logic [ADDR_W-1:0]      blockAddr;
    logic [BLOCK_W-1:0]     dataIn;
    logic                   flush;
    logic                   invalidate;
    logic                   hit;
    logic [WAY_W-1:0]       hitWay;
    logic                   dirtyBit;
    logic                   victimValid;
    logic [ADDR_W-1:0]      victimAddr;
    logic [BLOCK_W-1:0]     dataOut;
    logic                   wbValid;
    logic                   wbReady;
    logic [ADDR_W-1:0]      wbAddr;
    logic [BLOCK_W-1:0]     wbData;
    logic                   busy;
    logic                   flushDone;

    modport slave (
        input  en, wen, dmemWen, bytesAccess, blockAddr, dataIn, flush, invalidate, wbReady,
        output hit, hitWay, dirtyBit, victimValid, victimAddr, dataOut, wbValid, wbAddr, wbData,
               busy, flushDone
    );

    modport master (
        output en, wen, dmemWen, bytesAccess, blockAddr, dataIn, flush, invalidate, wbReady,
        input  hit, hitWay, dirtyBit, victimValid, victimAddr, dataOut, wbValid, wbAddr, wbData,
               busy, flushDone
    );
endinterface

// File: rtl/d_sram_assoc.sv
// N-way set-associative D-cache storage with LRU victim selection and a flush write-back walker.
// Latency: lookup results are registered and valid one cycle after an accepted access.
// Backpressure: accesses are refused while busy; each flush write-back waits for wbReady.
module d_sram_assoc #(
    parameter int WAYS        = 2,
    parameter int SETS        = 64,
    parameter int BLOCK_BYTES = 16,
    parameter int TAG_W       = 22
) (
    input  logic          clk,
    input  logic          rst,
    d_sram_assoc_if.slave bus
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ADDR_W  = TAG_W + INDEX_W;
    localparam int BLOCK_W = 8 * BLOCK_BYTES;
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

    logic [TAG_W-1:0]   tagArr   [SETS][WAYS];
    logic [BLOCK_W-1:0] dataArr  [SETS][WAYS];
    logic [WAYS-1:0]    validArr [SETS];
    logic [WAYS-1:0]    dirtyArr [SETS];
    logic [WAY_W-1:0]   ageArr   [SETS][WAYS];

    state_t             state, stateNext;
    logic [INDEX_W-1:0] scanSet;
    logic [WAY_W-1:0]   scanWay;
    logic               invLatched, lastLine;
    logic               scanAdvance, scanClrValid, scanClrDirty;
    logic               busyInt, wbValidInt, flushDoneInt;

    logic [INDEX_W-1:0] accIdx;
    logic [TAG_W-1:0]   accTag;
    logic               accept, doFill, doWrite, doTouch;
    logic               hitNow, foundInv;
    logic [WAY_W-1:0]   hitIdx, vicIdx, tgtWay, maxAge, oldAge;
    logic [BLOCK_W-1:0] mergedData;

    logic               hitQ, dirtyQ, victimValidQ;
    logic [WAY_W-1:0]   hitWayQ;
    logic [ADDR_W-1:0]  victimAddrQ;
    logic [BLOCK_W-1:0] dataOutQ;

    assign accIdx  = bus.blockAddr[INDEX_W-1:0];
    assign accTag  = bus.blockAddr[ADDR_W-1:INDEX_W];
    assign accept  = bus.en && !busyInt;
    assign doFill  = accept && bus.wen && bus.dmemWen;
    assign doWrite = accept && bus.wen && !bus.dmemWen && hitNow;
    assign doTouch = doFill || (accept && hitNow);
    // A fill of an already-present tag reuses that way so tags never duplicate.
    assign tgtWay  = hitNow ? hitIdx : vicIdx;
    assign oldAge  = ageArr[accIdx][tgtWay];

    always_comb begin
        hitNow   = 1'b0;
        hitIdx   = '0;
        foundInv = 1'b0;
        vicIdx   = '0;
        maxAge   = ageArr[accIdx][0];
        for (int w = 0; w < WAYS; w++) begin
            if (validArr[accIdx][w] && (tagArr[accIdx][w] == accTag)) begin
                hitNow = 1'b1;
                hitIdx = WAY_W'(w);
            end
            if (!foundInv && !validArr[accIdx][w]) begin
                foundInv = 1'b1;
                vicIdx   = WAY_W'(w);
            end
        end
        if (!foundInv) begin
            for (int w = 1; w < WAYS; w++) begin
                if (ageArr[accIdx][w] > maxAge) begin
                    maxAge = ageArr[accIdx][w];
                    vicIdx = WAY_W'(w);
                end
            end
        end
    end

    always_comb begin
        mergedData = dataArr[accIdx][hitIdx];
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (bus.bytesAccess[i]) mergedData[8*i +: 8] = bus.dataIn[8*i +: 8];
        end
    end

    assign lastLine = (scanSet == INDEX_W'(SETS - 1)) && (scanWay == WAY_W'(WAYS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        scanAdvance  = 1'b0;
        scanClrValid = 1'b0;
        scanClrDirty = 1'b0;
        busyInt      = 1'b0;
        wbValidInt   = 1'b0;
        flushDoneInt = 1'b0;
        case (state)
            IDLE: if (bus.flush) stateNext = SCAN;
            SCAN: begin
                busyInt = 1'b1;
                if (validArr[scanSet][scanWay] && dirtyArr[scanSet][scanWay]) begin
                    stateNext = WB;
                end else begin
                    scanClrValid = invLatched;
                    scanAdvance  = 1'b1;
                    if (lastLine) stateNext = DONE;
                end
            end
            WB: begin
                busyInt    = 1'b1;
                wbValidInt = 1'b1;
                if (bus.wbReady) begin
                    scanClrDirty = 1'b1;
                    scanClrValid = invLatched;
                    scanAdvance  = 1'b1;
                    stateNext    = lastLine ? DONE : SCAN;
                end
            end
            DONE: begin
                flushDoneInt = 1'b1;
                stateNext    = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scanSet    <= '0;
            scanWay    <= '0;
            invLatched <= 1'b0;
        end else if (state == IDLE) begin
            scanSet <= '0;
            scanWay <= '0;
            if (bus.flush) invLatched <= bus.invalidate;
        end else if (scanAdvance) begin
            if (scanWay == WAY_W'(WAYS - 1)) begin
                scanWay <= '0;
                scanSet <= scanSet + 1'b1;
            end else begin
                scanWay <= scanWay + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                validArr[s] <= '0;
                dirtyArr[s] <= '0;
                for (int w = 0; w < WAYS; w++) ageArr[s][w] <= '0;
            end
        end else begin
            // Ages start out tied after reset; counting equal ages as younger turns ties into a strict order.
            if (doTouch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == tgtWay)
                        ageArr[accIdx][w] <= '0;
                    else if ((ageArr[accIdx][w] <= oldAge) && (ageArr[accIdx][w] != AGE_MAX))
                        ageArr[accIdx][w] <= ageArr[accIdx][w] + 1'b1;
                end
            end
            if (doFill) begin
                validArr[accIdx][tgtWay] <= 1'b1;
                dirtyArr[accIdx][tgtWay] <= 1'b0;
            end
            if (doWrite)      dirtyArr[accIdx][tgtWay]   <= 1'b1;
            if (scanClrValid) validArr[scanSet][scanWay] <= 1'b0;
            if (scanClrDirty) dirtyArr[scanSet][scanWay] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && doFill) begin
            tagArr[accIdx][tgtWay]  <= accTag;
            dataArr[accIdx][tgtWay] <= bus.dataIn;
        end else if (!rst && doWrite) begin
            dataArr[accIdx][tgtWay] <= mergedData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hitQ         <= 1'b0;
            hitWayQ      <= '0;
            dirtyQ       <= 1'b0;
            victimValidQ <= 1'b0;
            victimAddrQ  <= '0;
            dataOutQ     <= '0;
        end else if (accept) begin
            if (doFill) begin
                hitQ         <= 1'b1;
                hitWayQ      <= tgtWay;
                dirtyQ       <= 1'b0;
                victimValidQ <= 1'b0;
                victimAddrQ  <= '0;
                dataOutQ     <= bus.dataIn;
            end else if (hitNow) begin
                hitQ         <= 1'b1;
                hitWayQ      <= hitIdx;
                dirtyQ       <= bus.wen || dirtyArr[accIdx][hitIdx];
                victimValidQ <= 1'b0;
                victimAddrQ  <= '0;
                dataOutQ     <= bus.wen ? mergedData : dataArr[accIdx][hitIdx];
            end else begin
                hitQ         <= 1'b0;
                hitWayQ      <= vicIdx;
                dirtyQ       <= validArr[accIdx][vicIdx] && dirtyArr[accIdx][vicIdx];
                victimValidQ <= validArr[accIdx][vicIdx];
                victimAddrQ  <= validArr[accIdx][vicIdx] ? {tagArr[accIdx][vicIdx], accIdx} : '0;
                dataOutQ     <= validArr[accIdx][vicIdx] ? dataArr[accIdx][vicIdx] : '0;
            end
        end
    end

    assign bus.hit         = hitQ;
    assign bus.hitWay      = hitWayQ;
    assign bus.dirtyBit    = dirtyQ;
    assign bus.victimValid = victimValidQ;
    assign bus.victimAddr  = victimAddrQ;
    assign bus.dataOut     = dataOutQ;
    assign bus.busy        = busyInt;
    assign bus.flushDone   = flushDoneInt;
    assign bus.wbValid     = wbValidInt;
    assign bus.wbAddr      = wbValidInt ? {tagArr[scanSet][scanWay], scanSet} : '0;
    assign bus.wbData      = wbValidInt ? dataArr[scanSet][scanWay] : '0;
endmodule

// File: tb/tb_d_sram_assoc.sv
// Directed vector table for lookups/fills/writes plus hand sequences for flush and reset-abort.
module tb_d_sram_assoc;
    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    d_sram_assoc_if bus ();
    d_sram_assoc dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wen;
        logic         dmem;
        logic [15:0]  bytes;
        logic [27:0]  addr;
        logic [127:0] din;
        logic         eHit;
        logic         eWay;
        logic         eDirty;
        logic         eVV;
        logic [27:0]  eVA;
        logic [127:0] eData;
    } vec_t;

    localparam logic [27:0]  A_FF  = 28'hFFFFFC0;  // tag 0x3FFFFF, set 0
    localparam logic [27:0]  A_0   = 28'h0000000;  // tag 0, set 0
    localparam logic [27:0]  A_5   = 28'h0000140;  // tag 5, set 0
    localparam logic [27:0]  A_7   = 28'h00001C0;  // tag 7, set 0
    localparam logic [27:0]  A_63  = 28'h048D17F;  // tag 0x12345, set 63
    localparam logic [27:0]  A_10  = 28'h00000CA;  // tag 3, set 10
    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [127:0] MA    = 128'hAAFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [127:0] D5    = 128'h05050505_05050505_05050505_05050505;
    localparam logic [127:0] D63   = 128'h63636363_63636363_63636363_63636363;
    localparam logic [127:0] D63M  = 128'h63636363_63636363_63636363_6363635A;
    localparam logic [127:0] DX    = 128'hDEADBEEF_00112233_44556677_8899AABB;

    vec_t vecs [24];

    function automatic vec_t mk(input logic w, d, input logic [15:0] b, input logic [27:0] a,
                                input logic [127:0] di, input logic h, hw, dy, vv,
                                input logic [27:0] va, input logic [127:0] dat);
        vec_t v;
        v.wen = w; v.dmem = d; v.bytes = b; v.addr = a; v.din = di;
        v.eHit = h; v.eWay = hw; v.eDirty = dy; v.eVV = vv; v.eVA = va; v.eData = dat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic doAcc(input logic w, d, input logic [15:0] b, input logic [27:0] a,
                         input logic [127:0] di);
        @(negedge clk);
        bus.en = 1'b1; bus.wen = w; bus.dmemWen = d;
        bus.bytesAccess = b; bus.blockAddr = a; bus.dataIn = di;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
    endtask

    task automatic runVec(input int i);
        vec_t v;
        v = vecs[i];
        doAcc(v.wen, v.dmem, v.bytes, v.addr, v.din);
        chk($sformatf("v%0d.hit", i), bus.hit, v.eHit);
        chk($sformatf("v%0d.hitWay", i), bus.hitWay, v.eWay);
        chk($sformatf("v%0d.dirtyBit", i), bus.dirtyBit, v.eDirty);
        chk($sformatf("v%0d.dataOut", i), bus.dataOut, v.eData);
        if (!v.eHit) begin
            chk($sformatf("v%0d.victimValid", i), bus.victimValid, v.eVV);
            chk($sformatf("v%0d.victimAddr", i), bus.victimAddr, v.eVA);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0]  expWbAddr [2];
        logic [127:0] expWbData [2];
        int  handshakes, stall;
        logic done, wbBad, busyDrop, seen, pulse;

        //           wen  dmem bytes    addr  din           hit way dty vv  vaddr  data
        vecs[0]  = mk(0, 0, 16'h0000, A_0,  '0,             0, 0, 0, 0, '0,    '0);
        vecs[1]  = mk(1, 1, 16'h0000, A_FF, ONES,           1, 0, 0, 0, '0,    ONES);
        vecs[2]  = mk(1, 1, 16'h0000, A_0,  '0,             1, 1, 0, 0, '0,    '0);
        vecs[3]  = mk(0, 0, 16'h0000, A_FF, '0,             1, 0, 0, 0, '0,    ONES);
        vecs[4]  = mk(0, 0, 16'h0000, A_0,  '0,             1, 1, 0, 0, '0,    '0);
        vecs[5]  = mk(1, 0, 16'h8000, A_FF, {8'hAA, 120'h0}, 1, 0, 1, 0, '0,   MA);
        vecs[6]  = mk(0, 0, 16'h0000, A_FF, '0,             1, 0, 1, 0, '0,    MA);
        vecs[7]  = mk(0, 0, 16'h0000, A_0,  '0,             1, 1, 0, 0, '0,    '0);
        vecs[8]  = mk(0, 0, 16'h0000, A_5,  '0,             0, 0, 1, 1, A_FF,  MA);
        vecs[9]  = mk(1, 1, 16'h0000, A_5,  D5,             1, 0, 0, 0, '0,    D5);
        vecs[10] = mk(0, 0, 16'h0000, A_FF, '0,             0, 1, 0, 1, A_0,   '0);
        vecs[11] = mk(0, 0, 16'h0000, A_0,  '0,             1, 1, 0, 0, '0,    '0);
        vecs[12] = mk(0, 0, 16'h0000, A_5,  '0,             1, 0, 0, 0, '0,    D5);
        vecs[13] = mk(1, 0, 16'hFFFF, A_7,  ONES,           0, 1, 0, 1, A_0,   '0);
        vecs[14] = mk(0, 0, 16'h0000, A_7,  '0,             0, 1, 0, 1, A_0,   '0);
        vecs[15] = mk(1, 1, 16'h0000, A_0,  DX,             1, 1, 0, 0, '0,    DX);
        vecs[16] = mk(0, 0, 16'h0000, A_0,  '0,             1, 1, 0, 0, '0,    DX);
        vecs[17] = mk(1, 0, 16'h0000, A_5,  ONES,           1, 0, 1, 0, '0,    D5);
        vecs[18] = mk(1, 1, 16'h0000, A_63, D63,            1, 0, 0, 0, '0,    D63);
        vecs[19] = mk(1, 0, 16'h0001, A_63, 128'h5A,        1, 0, 1, 0, '0,    D63M);
        vecs[20] = mk(0, 0, 16'h0000, A_63, '0,             1, 0, 1, 0, '0,    D63M);
        vecs[21] = mk(0, 0, 16'h0000, A_5,  '0,             0, 0, 0, 0, '0,    '0);
        vecs[22] = mk(0, 0, 16'h0000, A_0,  '0,             0, 0, 0, 0, '0,    '0);
        vecs[23] = mk(0, 0, 16'h0000, A_63, '0,             0, 0, 0, 0, '0,    '0);
        expWbAddr[0] = A_5;  expWbData[0] = D5;
        expWbAddr[1] = A_63; expWbData[1] = D63M;

        rst = 1'b1;
        bus.en = 1'b0; bus.wen = 1'b0; bus.dmemWen = 1'b0; bus.bytesAccess = '0;
        bus.blockAddr = '0; bus.dataIn = '0; bus.flush = 1'b0; bus.invalidate = 1'b0;
        bus.wbReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.hit", bus.hit, 1'b0);
        chk("reset.busy", bus.busy, 1'b0);
        chk("reset.wbValid", bus.wbValid, 1'b0);
        chk("reset.flushDone", bus.flushDone, 1'b0);
        chk("reset.dataOut", bus.dataOut, '0);

        for (int i = 0; i < 21; i++) runVec(i);

        // Flush with invalidate, started alongside an access that must still complete.
        @(negedge clk);
        bus.en = 1'b1; bus.wen = 1'b0; bus.dmemWen = 1'b0; bus.blockAddr = A_0;
        bus.flush = 1'b1; bus.invalidate = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0; bus.invalidate = 1'b0;
        bus.blockAddr = A_5;
        chk("flush.start.busy", bus.busy, 1'b1);
        chk("flush.start.hit", bus.hit, 1'b1);
        chk("flush.start.dataOut", bus.dataOut, DX);
        handshakes = 0; stall = 0; done = 1'b0; wbBad = 1'b0; busyDrop = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (bus.wbReady) begin
                bus.wbReady = 1'b0;
                handshakes++;
                stall = 0;
            end
            if (bus.flushDone) begin
                done = 1'b1;
                bus.en = 1'b0;
                if (bus.busy) busyDrop = 1'b1;
            end else begin
                if (!bus.busy) busyDrop = 1'b1;
                if (bus.wbValid) begin
                    if (handshakes >= 2) wbBad = 1'b1;
                    else if (bus.wbAddr !== expWbAddr[handshakes] ||
                             bus.wbData !== expWbData[handshakes]) wbBad = 1'b1;
                    stall++;
                    if (stall == 4) bus.wbReady = 1'b1;
                end
            end
        end
        chk("flush.done_seen", done, 1'b1);
        chk("flush.handshakes", handshakes, 2);
        chk("flush.wb_bad", wbBad, 1'b0);
        chk("flush.busy_profile", busyDrop, 1'b0);
        @(negedge clk);
        chk("flush.done_pulse_width", bus.flushDone, 1'b0);
        chk("flush.after.busy", bus.busy, 1'b0);
        chk("flush.hold.hit", bus.hit, 1'b1);
        chk("flush.hold.hitWay", bus.hitWay, 1'b1);
        chk("flush.hold.dataOut", bus.dataOut, DX);

        for (int i = 21; i < 24; i++) runVec(i);

        // Reset in the middle of a write-back aborts the walk without flushDone.
        doAcc(1'b1, 1'b1, 16'h0000, A_10, D5);
        doAcc(1'b1, 1'b0, 16'h0001, A_10, 128'h77);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (bus.wbValid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("abort.wb_seen", seen, 1'b1);
        chk("abort.wbAddr", bus.wbAddr, A_10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", bus.busy, 1'b0);
        chk("abort.wbValid", bus.wbValid, 1'b0);
        chk("abort.hit", bus.hit, 1'b0);
        chk("abort.dataOut", bus.dataOut, '0);
        pulse = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.flushDone) pulse = 1'b1;
            @(negedge clk);
        end
        chk("abort.no_flushDone", pulse, 1'b0);
        doAcc(1'b0, 1'b0, 16'h0000, A_10, '0);
        chk("abort.read.hit", bus.hit, 1'b0);
        chk("abort.read.victimValid", bus.victimValid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/d_sram_assoc.md
Name: d_sram_assoc

Overview:
Parametrised N-way set-associative data-cache storage array, the successor to the direct-mapped D_SRAM. It holds tag, valid, dirty, LRU and data per line. It supports byte-masked CPU writes, whole-block fills from memory, and LRU victim selection with victim reporting on a miss. A flush engine walks every line and drains dirty blocks over a valid/ready write-back port. The block sits between the D-cache controller FSM and the memory interface.

Parameters:
WAYS, 2, associativity; power of two, 1..4 (1 gives direct-mapped behaviour).
SETS, 64, number of sets; power of two; INDEX_W = clog2(SETS).
BLOCK_BYTES, 16, bytes per block; BLOCK_W = 8*BLOCK_BYTES.
TAG_W, 22, tag bits; blockAddr is {tag, index}, width TAG_W+INDEX_W.

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  synchronous reset, active-high
en  in  1  access request; accepted only when busy=0
wen  in  1  0 = read lookup, 1 = write
dmemWen  in  1  with wen=1: 1 = fill from memory, 0 = CPU byte write
bytesAccess  in  BLOCK_BYTES  byte enables for CPU write; bit i covers dataIn[8i+7:8i]
blockAddr  in  TAG_W+INDEX_W  {tag, index}
dataIn  in  BLOCK_W  write/fill data
flush  in  1  one-cycle pulse that starts the flush walk
invalidate  in  1  sampled with flush; 1 = also clear valid bits during the walk
hit  out  1  registered hit for the previous accepted access
hitWay  out  clog2(WAYS) (min 1)  hit way, or the chosen victim way on a miss
dirtyBit  out  1  hit: line dirty; miss: victim dirty
victimValid  out  1  miss: victim line valid
victimAddr  out  TAG_W+INDEX_W  miss: {victim tag, index}
dataOut  out  BLOCK_W  hit: line data; miss: victim data
wbValid  out  1  flush write-back block presented
wbReady  in  1  write-back accepted
wbAddr  out  TAG_W+INDEX_W  flush write-back address
wbData  out  BLOCK_W  flush write-back data
busy  out  1  flush in progress
flushDone  out  1  one-cycle pulse when the walk completes

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - Clears all valid, dirty and LRU state.
  - Returns the FSM to IDLE.
  - Clears every output to 0, including hit, victimValid, wbValid, busy and flushDone.
  - Data and tag arrays are not cleared.
  - Reset during a flush aborts the walk; no flushDone is issued.
- Access latency: an access is accepted when en=1 and busy=0. All lookup outputs are registered and valid on the next cycle. They hold their value until the next accepted access.
- Hit: some way has valid=1 and a matching tag. More than one matching way is impossible by construction.
- Victim select on a miss:
  - Use the lowest-numbered invalid way.
  - Otherwise use the LRU way.
  - Report it on hitWay, victimValid, victimAddr, dirtyBit and dataOut.
- LRU:
  - Each way in a set has a clog2(WAYS)-bit age; 0 means most recently used.
  - A hit or fill makes that way age 0; ways younger than its old age increment by 1.
  - A miss lookup does not update LRU.
- Read lookup (wen=0): no state change other than the LRU update on a hit.
- CPU write (wen=1, dmemWen=0):
  - On a hit, write only the enabled bytes, set dirty=1 and update LRU.
  - On a miss, change no state and report hit=0 with the victim info.
  - bytesAccess=0 on a hit still sets dirty.
- Fill (wen=1, dmemWen=1):
  - Write the whole block into the victim way chosen at that cycle.
  - Set tag, valid=1, dirty=0 and update LRU.
  - Report hit=1 with hitWay equal to the filled way.
  - If the tag is already present, overwrite that way instead, so no duplicate tags arise.
- Same-set back-to-back accesses: the second access sees the first access's update (write-first ordering, no stale read).
- Flush FSM states: IDLE, SCAN, WB, DONE.
  - IDLE -> SCAN on flush=1 with rst=0; latch invalidate; busy=1 from the next cycle.
  - If en and flush are high in the same cycle with busy=0, the access completes normally and the walk starts next cycle.
  - SCAN checks one (set, way) per cycle, in set-major then way order.
  - A valid dirty line goes to WB; otherwise, if invalidate is latched, clear valid.
  - WB holds wbValid=1 with wbAddr and wbData stable until wbReady=1. On the handshake, clear dirty (and valid if invalidate) and return to SCAN at the next line.
  - After the last line -> DONE: flushDone=1 for one cycle and busy drops in that same cycle -> IDLE.
  - A flush pulse while busy is ignored.
- Worst-case walk length: SETS*WAYS scan cycles plus write-back stalls.

Test Plan:
1. Reset, then read blockAddr 0 -> hit=0, victimValid=0, hitWay=0, all outputs 0.
2. Fill tag 0x3FFFFF idx 0 with all-ones, then fill tag 0 idx 0 with zeros, then read each -> both hit=1 on hitWay 0 and 1 respectively, dataOut all-ones / zeros, dirtyBit=0.
3. CPU write bytesAccess=0x8000, dataIn[127:120]=0xAA to tag 0x3FFFFF idx 0, then read -> hit=1, dirtyBit=1, dataOut = 0xAA followed by 0xFF in the remaining bytes.
4. Read tag 0 (makes it MRU), then lookup tag 5 idx 0 -> hit=0, hitWay=0, victimValid=1, dirtyBit=1, victimAddr={0x3FFFFF, 0}.
5. Fill tag 5 idx 0 after step 4 -> way 0 replaced; tag 0x3FFFFF now misses; tag 0 and tag 5 hit.
6. Dirty lines in sets 0 and 63, flush with invalidate=1, wbReady held low 3 cycles per block -> exactly two wbValid handshakes with correct wbAddr/wbData, busy high throughout, en ignored while busy, one flushDone pulse, then all lookups miss.
